// File: rtl/request_encoder.sv
// Sequential 8-to-3 request encoder with valid/ready grant handshake.
// Define REQUEST_ENCODER_RR_EN for round-robin instead of fixed priority.
module request_encoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       ready,
  output logic       valid,
  output logic [2:0] address,
  output logic [7:0] pending,
  output logic       dup
);

  typedef enum logic {
    IDLE,
    OFFER
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [2:0] addr_nx;
  logic       hs;
  logic [7:0] clear;
  logic [7:0] pend_nx;
  logic [2:0] sel;

  assign valid   = (state == OFFER);
  assign hs      = valid & ready;
  assign clear   = hs ? (8'h01 << address) : 8'h00;
  assign pend_nx = (pending & ~clear) | req;

`ifdef REQUEST_ENCODER_RR_EN
  logic [2:0] ptr;
  logic [2:0] ptr_eff;

  // Search must see the grant being served this cycle as "last".
  assign ptr_eff = hs ? address : ptr;

  function automatic logic [2:0] pick(
    input logic [7:0] v,
    input logic [2:0] start
  );
    logic       found;
    logic [2:0] idx;
    pick  = 3'd0;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = start + k[2:0];
      if (!found && v[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  assign sel = pick(pend_nx, ptr_eff + 3'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 3'd7;
    end else if (hs) begin
      ptr <= address;
    end
  end
`else
  function automatic logic [2:0] pick(
    input logic [7:0] v
  );
    pick = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) pick = i[2:0];
    end
  endfunction

  assign sel = pick(pend_nx);
`endif

  always_comb begin
    state_nx = state;
    addr_nx  = address;
    unique case (state)
      IDLE: begin
        if (|pend_nx) begin
          addr_nx  = sel;
          state_nx = OFFER;
        end
      end
      OFFER: begin
        if (hs) begin
          if (|pend_nx) begin
            addr_nx = sel;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      address <= 3'd0;
      pending <= 8'h00;
      dup     <= 1'b0;
    end else begin
      state   <= state_nx;
      address <= addr_nx;
      pending <= pend_nx;
      dup     <= |(req & pending & ~clear);
    end
  end

endmodule

// File: doc/request_encoder.md
# request_encoder

Sequential 8-to-3 priority encoder: the inverse of the processor's 3-to-8 address decoder. It collects up to eight request lines into a pending register, selects one, and presents its 3-bit index on a valid/ready handshake for the control unit to consume. A served request is cleared on handshake, and the next pending request is offered without a bubble cycle.

## Interface

Parameters:
- none; width is fixed at 8 requests and a 3-bit address.

Ports:
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `req`  input  8  request lines, sampled every rising edge; `req[i]`=1 marks request i pending.
- `ready`  input  1  consumer accepts the offered address.
- `valid`  output  1  `address` holds a pending request index.
- `address`  output  3  index of the offered request; meaningful only while `valid`=1.
- `pending`  output  8  current pending register.
- `dup`  output  1  one-cycle pulse: at least one request arrived on an already-pending bit and was merged.

## Operation

- **Handshake.** Occurs in any cycle with `valid`=1 and `ready`=1. The clear mask is `onehot(address)` in a handshake cycle and 0 otherwise.
- **Pending update at each edge.** `pending <= (pending & ~clear) | req`.
  - A `req[i]` that coincides with the handshake of index i keeps bit i set, so it is a fresh request.
- **Two states.**
  - **IDLE** (`valid`=0):
    - At an edge where the next pending value is non-zero, load `address` from the selector applied to that next value and go to OFFER.
    - Otherwise stay in IDLE.
  - **OFFER** (`valid`=1):
    - Without a handshake, `address` and `valid` are held stable, even if a higher-priority request arrives.
    - On a handshake with a non-zero next pending value: stay in OFFER and load the new `address` from it (back-to-back grants).
    - On a handshake with a zero next pending value: go to IDLE.
- **Selector.** Fixed priority: the lowest set index wins, so index 0 has the highest priority and matches decoder output 0.
- **dup.** Registered: `dup <= |(req & pending & ~clear)`.
- **Consistency.** `address` always names a bit set in `pending` while `valid`=1.
- **Throughput.** One grant per cycle while `ready` stays high.

## Timing

- **Reset values.** `valid`=0, `address`=3'b000, `pending`=8'h00, `dup`=0, state IDLE, round-robin pointer=3'd7.
- **Reset mid-operation.** All pending requests are dropped and no handshake completes. Outputs reach their reset values asynchronously and stay there until the first edge after `rst_n` rises.
- **Latency.** A `req` sampled at edge E with the block in IDLE gives `valid`=1 with the correct `address` immediately after E, i.e. a 1-cycle latency.
- **Next grant.** The grant following a handshake at edge E is visible immediately after E.
- **dup timing.** `dup` is visible after the edge that merged the request, for exactly one cycle.
- **Simultaneous events.**
  - A new `req` together with a handshake is merged before selection.
  - With all 8 bits pending, the block drains in 8 handshakes.

## Configuration

- **Macro `REQUEST_ENCODER_RR_EN`.**
  - **Defined:** round-robin selection.
    - A 3-bit pointer holds the last granted index.
    - The search starts at pointer+1 and wraps 7 to 0.
    - The pointer updates only on a handshake, to the served `address`.
    - With reset pointer 7, the first search starts at index 0.
  - **Not defined:** fixed lowest-index priority. No pointer register exists.
- **Unchanged by the macro:** ports, latency and the handshake.

## Test plan

- **Reset then single request.** Hold `ready`=0 and pulse `req`=8'h20 for one cycle → after the next edge: `valid`=1, `address`=5, `pending`=8'h20. Both stay stable for 4 cycles. Then `ready`=1 for one cycle → `valid`=0, `pending`=8'h00.
- **Fixed-priority drain (macro undefined).** `req`=8'hA5 for one cycle, `ready` held at 1 → `address` sequence 0, 2, 5, 7 on consecutive cycles, then `valid`=0.
- **Round-robin (macro defined).** With `req`=8'h81 held for 4 cycles and `ready`=1 → grants alternate 0, 7, 0, 7. Under fixed priority the same stimulus gives 0, 0, 0, 0.
- **Merge and dup.** `req`=8'h08 on two consecutive cycles with `ready`=0 → `dup`=1 for exactly one cycle after the second edge and `pending`=8'h08. Then one handshake → `valid`=0.
- **Re-request on handshake.** `address`=3 is offered; in the cycle where `ready`=1, also assert `req[3]` → `valid` stays 1, `address`=3, `dup`=0.
- **Asynchronous reset mid-operation.** With `pending`=8'hFF and `valid`=1, drop `rst_n` between edges → `valid`, `pending` and `address` read 0 before the next edge and stay 0 until release.
